// File: rtl/bin_search_engine.sv
// Binary search over an external sorted RAM with configurable read latency.
// Supports exact-match and lower-bound (first word >= key) lookups.
module bin_search_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  input  logic              mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W:0]   probes
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CMP, DONE} state_t;

  // Bounds carry one extra bit so hi can hold DEPTH without wrapping.
  localparam logic [ADDR_W:0] LP_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LP_ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [1:0]      LP_WAIT_LAST = 2'(RD_LAT - 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_target;
  logic                r_mode;
  logic [ADDR_W:0]     r_lo;
  logic [ADDR_W:0]     r_hi;
  logic [ADDR_W:0]     r_mid;
  logic [1:0]          r_wait_cnt;

  logic [ADDR_W:0]     w_mid;
  logic                w_lt;
  logic                w_eq;
  logic [ADDR_W:0]     w_lo_nxt;
  logic [ADDR_W:0]     w_hi_nxt;

  always_comb begin
    w_mid    = r_lo + ((r_hi - r_lo) >> 1);
    w_lt     = (mem_rdata < r_target);
    w_eq     = (mem_rdata == r_target);
    w_lo_nxt = w_lt ? (r_mid + LP_ONE) : r_lo;
    w_hi_nxt = w_lt ? r_hi : r_mid;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register, including the search bounds and wait counter,
    // is reset so an aborted search leaves nothing stale behind.
    if (!reset_n) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_mode     <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_mid      <= '0;
      r_wait_cnt <= '0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      index      <= '0;
      probes     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_target <= target;
            r_mode   <= mode;
            r_lo     <= '0;
            r_hi     <= LP_DEPTH;
            probes   <= '0;
            found    <= 1'b0;
            index    <= '0;
            busy     <= 1'b1;
            r_state  <= ADDR;
          end
        end
        ADDR: begin
          r_mid      <= w_mid;
          mem_addr   <= w_mid[ADDR_W-1:0];
          probes     <= probes + LP_ONE;
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == LP_WAIT_LAST) begin
            r_state <= CMP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        CMP: begin
          if (!r_mode && w_eq) begin
            found   <= 1'b1;
            index   <= r_mid[ADDR_W-1:0];
            r_state <= DONE;
          end else begin
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_state <= (w_lo_nxt == w_hi_nxt) ? DONE : ADDR;
          end
        end
        DONE: begin
          // Exact-mode misses keep the cleared result from launch.
          if (r_mode) begin
            found <= (r_lo != LP_DEPTH);
            index <= (r_lo != LP_DEPTH) ? r_lo[ADDR_W-1:0] : '0;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_search_engine.sv
// Bench for bin_search_engine: RD_LAT=1 and RD_LAT=3 instances share stimulus,
// RAM holds mem[i]=2*i+1, results are scored from per-instance queues.
module tb_bin_search_engine;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] target;
  logic       mode;

  logic [4:0] addr1, addr3, index1, index3;
  logic [7:0] rdata1, rdata3;
  logic       busy1, busy3, done1, done3, found1, found3;
  logic [5:0] probes1, probes3;
  logic [7:0] pipe3 [3];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic prev_done1 = 1'b0;
  logic prev_done3 = 1'b0;

  typedef struct {
    logic       found;
    logic [4:0] index;
    logic [5:0] probes;
    int         start_cyc;
    int         lat;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [7:0] target;
    logic       found;
    logic [4:0] index;
  } vec_t;

  exp_t q1[$];
  exp_t q3[$];

  bin_search_engine #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .target(target), .mode(mode),
    .mem_addr(addr1), .mem_rdata(rdata1), .busy(busy1), .done(done1),
    .found(found1), .index(index1), .probes(probes1)
  );

  bin_search_engine #(.DATA_W(8), .ADDR_W(5), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .target(target), .mode(mode),
    .mem_addr(addr3), .mem_rdata(rdata3), .busy(busy3), .done(done3),
    .found(found3), .index(index3), .probes(probes3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [4:0] a);
    return {2'b00, a, 1'b1};
  endfunction

  // RAM models: data valid RD_LAT cycles after the address changes.
  always @(posedge clk) rdata1 <= mem_val(addr1);
  always @(posedge clk) begin
    pipe3[0] <= mem_val(addr3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata3 = pipe3[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_probes(input logic m, input logic [7:0] t);
    int lo = 0;
    int hi = 32;
    int mid;
    int n = 0;
    while (lo != hi) begin
      mid = lo + (hi - lo) / 2;
      n++;
      if (!m && mem_val(5'(mid)) == t) return n;
      if (mem_val(5'(mid)) < t) lo = mid + 1;
      else hi = mid;
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic score(input int which, input logic d, input logic f,
                       input logic [4:0] idx, input logic [5:0] p, input logic pd);
    exp_t  e;
    string nm;
    nm = (which == 1) ? "lat1" : "lat3";
    if ((which == 1 && q1.size() == 0) || (which == 3 && q3.size() == 0)) begin
      check({nm, "_spurious_done"}, 32'(d), 0);
    end else begin
      e = (which == 1) ? q1.pop_front() : q3.pop_front();
      check({nm, "_found"},   32'(f),   32'(e.found));
      check({nm, "_index"},   32'(idx), 32'(e.index));
      check({nm, "_probes"},  32'(p),   32'(e.probes));
      check({nm, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
      check({nm, "_pulse"},   32'(pd),  0);
      check({nm, "_probe_bound"}, 32'(p <= 6'd6), 1);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (done1) score(1, done1, found1, index1, probes1, prev_done1);
      if (done3) score(3, done3, found3, index3, probes3, prev_done3);
    end
    prev_done1 <= done1;
    prev_done3 <= done3;
  end

  task automatic push_exp(input logic ef, input logic [4:0] ei, input int n, input int s1, input int s3);
    exp_t e;
    e.found = ef; e.index = ei; e.probes = 6'(n);
    e.start_cyc = s1; e.lat = n * 3 + 1; q1.push_back(e);
    e.start_cyc = s3; e.lat = n * 5 + 1; q3.push_back(e);
  endtask

  task automatic launch(input logic m, input logic [7:0] t, input logic ef, input logic [4:0] ei);
    @(negedge clk);
    start = 1'b1; target = t; mode = m;
    push_exp(ef, ei, model_probes(m, t), cyc + 1, cyc + 1);
    @(negedge clk);
    start = 1'b0; target = 8'($urandom); mode = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (q1.size() != 0 || q3.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q3.size() != 0) begin
      check("done_timeout", 32'(q1.size() + q3.size()), 0);
      q1.delete();
      q3.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string p, input logic b, input logic d, input logic f,
                          input logic [4:0] i, input logic [5:0] pr, input logic [4:0] a);
    check({p, "_busy"}, 32'(b), 0);
    check({p, "_done"}, 32'(d), 0);
    check({p, "_found"}, 32'(f), 0);
    check({p, "_index"}, 32'(i), 0);
    check({p, "_probes"}, 32'(pr), 0);
    check({p, "_mem_addr"}, 32'(a), 0);
  endtask

  vec_t vecs[13];

  initial begin
    int s;
    int n;
    vecs[0]  = '{1'b0, 8'd21,  1'b1, 5'd10};
    vecs[1]  = '{1'b0, 8'd20,  1'b0, 5'd0};
    vecs[2]  = '{1'b0, 8'd1,   1'b1, 5'd0};
    vecs[3]  = '{1'b0, 8'd63,  1'b1, 5'd31};
    vecs[4]  = '{1'b1, 8'd20,  1'b1, 5'd10};
    vecs[5]  = '{1'b1, 8'd0,   1'b1, 5'd0};
    vecs[6]  = '{1'b1, 8'd64,  1'b0, 5'd0};
    vecs[7]  = '{1'b0, 8'd0,   1'b0, 5'd0};
    vecs[8]  = '{1'b0, 8'd255, 1'b0, 5'd0};
    vecs[9]  = '{1'b1, 8'd255, 1'b0, 5'd0};
    vecs[10] = '{1'b1, 8'd63,  1'b1, 5'd31};
    vecs[11] = '{1'b1, 8'd62,  1'b1, 5'd31};
    vecs[12] = '{1'b0, 8'd33,  1'b1, 5'd16};

    reset_n = 1'b0; start = 1'b0; target = '0; mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst_lat1", busy1, done1, found1, index1, probes1, addr1);
    chk_zero("rst_lat3", busy3, done3, found3, index3, probes3, addr3);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      launch(vecs[v].mode, vecs[v].target, vecs[v].found, vecs[v].index);
      wait_idle();
      repeat (3) @(negedge clk);
      check("hold_found", 32'(found1), 32'(vecs[v].found));
      check("hold_index", 32'(index1), 32'(vecs[v].index));
      check("idle_busy", 32'(busy1 | busy3), 0);
    end

    // A second request during a busy search must be dropped.
    launch(1'b0, 8'd21, 1'b1, 5'd10);
    repeat (2) @(negedge clk);
    start = 1'b1; target = 8'd5; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("ignored_start_index1", 32'(index1), 10);
    check("ignored_start_index3", 32'(index3), 10);
    check("ignored_start_busy", 32'(busy1 | busy3), 0);

    // Start held high relaunches from IDLE right after each done pulse.
    n = model_probes(1'b0, 8'd21);
    @(negedge clk);
    start = 1'b1; target = 8'd21; mode = 1'b0;
    s = cyc + 1;
    push_exp(1'b1, 5'd10, n, s, s);
    push_exp(1'b1, 5'd10, n, s + n * 3 + 2, s + n * 5 + 2);
    for (int i = 0; i < 200 && cyc < s + n * 5 + 4; i++) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset during WAIT aborts silently.
    @(negedge clk);
    start = 1'b1; target = 8'd21; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", 32'(busy1 & busy3), 1);
    reset_n = 1'b0;
    #1;
    chk_zero("abort_lat1", busy1, done1, found1, index1, probes1, addr1);
    chk_zero("abort_lat3", busy3, done3, found3, index3, probes3, addr3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    launch(1'b0, 8'd21, 1'b1, 5'd10);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected fewer cycles", n_checks);
    $fatal(1);
  end

endmodule
